// File: rtl/gate_wire.sv
// gate_wire: programmable 3-input sum-of-minterms gate with a registered copy, edge pulses
// and, when GATE_WIRE_TOGGLE_CNT_EN is defined, a saturating toggle counter.
module gate_wire_minterm #(
  parameter logic [2:0] IDX    = 3'd0,
  parameter logic       TT_BIT = 1'b0
) (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic m
);
  logic la, lb, lc;
  // Literal polarity is fixed at elaboration: true input for a 1 in the index, inverted for a 0.
  assign la = IDX[2] ? a : ~a;
  assign lb = IDX[1] ? b : ~b;
  assign lc = IDX[0] ? c : ~c;
  assign m  = TT_BIT & la & lb & lc;
endmodule

module gate_wire #(
  parameter logic [7:0] TRUTH_TABLE = 8'hEA,
  parameter int         CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             en,
  input  logic             cnt_clr,
  output logic             y,
  output logic             y_q,
  output logic             y_rise,
  output logic             y_fall,
  output logic [CNT_W-1:0] toggle_cnt
);
  logic [7:0] mt;

  for (genvar i = 0; i < 8; i++) begin : g_mt
    gate_wire_minterm #(
      .IDX    (3'(i)),
      .TT_BIT (TRUTH_TABLE[i])
    ) u_mt (
      .a (a),
      .b (b),
      .c (c),
      .m (mt[i])
    );
  end

  assign y = |mt;

  // y_q doubles as the previous-value register for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q    <= 1'b0;
      y_rise <= 1'b0;
      y_fall <= 1'b0;
    end else if (en) begin
      y_q    <= y;
      y_rise <= y & ~y_q;
      y_fall <= ~y & y_q;
    end else begin
      y_rise <= 1'b0;
      y_fall <= 1'b0;
    end
  end

`ifdef GATE_WIRE_TOGGLE_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (cnt_clr)
      cnt <= '0;
    else if (en && (y != y_q) && (cnt != {CNT_W{1'b1}}))
      cnt <= cnt + 1'b1;
  end

  assign toggle_cnt = cnt;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign toggle_cnt     = '0;
`endif
endmodule

// File: tb/tb_gate_wire.sv
// Self-checking bench for gate_wire: default-table instance (CNT_W=2) and XOR-table instance
// (CNT_W=8) share stimulus and are compared against a behavioural model.
module tb_gate_wire;
  logic       clk = 1'b0;
  logic       rst, a, b, c, en, cnt_clr;
  bit         run = 1'b0;
  logic       y0, yq0, r0, f0;
  logic [1:0] c0;
  logic       y1, yq1, r1, f1;
  logic [7:0] c1;

  int n_pass = 0;
  int n_chk  = 0;

  bit   cnt_on;
  logic mq[2], mr[2], mf[2];
  int   mc[2];
  int   mmax[2] = '{3, 255};

  always #5 if (run) clk = ~clk;

  gate_wire #(.TRUTH_TABLE(8'hEA), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .en(en), .cnt_clr(cnt_clr),
    .y(y0), .y_q(yq0), .y_rise(r0), .y_fall(f0), .toggle_cnt(c0)
  );

  gate_wire #(.TRUTH_TABLE(8'h96), .CNT_W(8)) dut_x (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .en(en), .cnt_clr(cnt_clr),
    .y(y1), .y_q(yq1), .y_rise(r1), .y_fall(f1), .toggle_cnt(c1)
  );

  // Instance 0 is y = (a & b) | c, instance 1 is the 3-input XOR.
  function automatic logic ref_y(int k, logic ia, logic ib, logic ic);
    return (k == 0) ? ((ia & ib) | ic) : (ia ^ ib ^ ic);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k] = 1'b0; mr[k] = 1'b0; mf[k] = 1'b0; mc[k] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/y0"},  32'(y0),  32'(ref_y(0, a, b, c)));
    chk({tag, "/yq0"}, 32'(yq0), 32'(mq[0]));
    chk({tag, "/r0"},  32'(r0),  32'(mr[0]));
    chk({tag, "/f0"},  32'(f0),  32'(mf[0]));
    chk({tag, "/c0"},  32'(c0),  32'(cnt_on ? mc[0] : 0));
    chk({tag, "/y1"},  32'(y1),  32'(ref_y(1, a, b, c)));
    chk({tag, "/yq1"}, 32'(yq1), 32'(mq[1]));
    chk({tag, "/r1"},  32'(r1),  32'(mr[1]));
    chk({tag, "/f1"},  32'(f1),  32'(mf[1]));
    chk({tag, "/c1"},  32'(c1),  32'(cnt_on ? mc[1] : 0));
  endtask

  // Drive one set of inputs, advance the model by one clock edge, then compare after the edge.
  task automatic step(input string tag, input logic [2:0] abc, input logic nen, input logic nclr);
    logic yk;
    {a, b, c} = abc; en = nen; cnt_clr = nclr;
    for (int k = 0; k < 2; k++) begin
      yk = ref_y(k, abc[2], abc[1], abc[0]);
      if (nen) begin
        mr[k] = yk & ~mq[k];
        mf[k] = ~yk & mq[k];
        if (nclr) mc[k] = 0;
        else if (yk != mq[k] && mc[k] < mmax[k]) mc[k] = mc[k] + 1;
        mq[k] = yk;
      end else begin
        mr[k] = 1'b0;
        mf[k] = 1'b0;
        if (nclr) mc[k] = 0;
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
`ifdef GATE_WIRE_TOGGLE_CNT_EN
    cnt_on = 1'b1;
`else
    cnt_on = 1'b0;
`endif
    rst = 1'b1; a = 1'b0; b = 1'b0; c = 1'b0; en = 1'b0; cnt_clr = 1'b0;
    model_reset();
    #1;
    check_all("reset");

    // Combinational sweep with the clock stopped.
    for (int i = 0; i < 8; i++) begin
      {a, b, c} = 3'(i);
      #1;
      chk($sformatf("comb_def_%0d", i), 32'(y0), 32'(ref_y(0, a, b, c)));
      chk($sformatf("comb_xor_%0d", i), 32'(y1), 32'(ref_y(1, a, b, c)));
      #99;
    end

    {a, b, c} = 3'b000;
    #1;
    rst = 1'b0;
    run = 1'b1;

    // Registered path and rising pulse.
    step("reg_000", 3'b000, 1'b1, 1'b0);
    chk("yq_low", 32'(yq0), 32'd0);
    step("reg_001", 3'b001, 1'b1, 1'b0);
    chk("yq_high", 32'(yq0), 32'd1);
    chk("rise_on", 32'(r0), 32'd1);
    step("reg_hold", 3'b001, 1'b1, 1'b0);
    chk("rise_off", 32'(r0), 32'd0);

    // Falling pulse, then the same transition with enable low.
    step("fall_010", 3'b010, 1'b1, 1'b0);
    chk("fall_on", 32'(f0), 32'd1);
    step("back_001", 3'b001, 1'b1, 1'b0);
    step("noen_010", 3'b010, 1'b0, 1'b0);
    chk("noen_hold", 32'(yq0), 32'd1);
    chk("noen_nofall", 32'(f0), 32'd0);

    // Counter saturation on the 2-bit instance, then clear beating a toggle.
    step("cnt_clr0", 3'b000, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++)
      step($sformatf("cnt_tog_%0d", i), (i % 2 == 0) ? 3'b001 : 3'b000, 1'b1, 1'b0);
    chk("cnt_sat", 32'(c0), cnt_on ? 32'd3 : 32'd0);
    step("cnt_clr_tog", 3'b000, 1'b1, 1'b1);
    chk("cnt_clr_pri", 32'(c0), 32'd0);
    step("cnt_clr_noen", 3'b001, 1'b0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 200; i++)
      step($sformatf("rnd_%0d", i), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 15) == 0));

    // Asynchronous reset between edges with y_q high.
    step("pre_rst", 3'b111, 1'b1, 1'b0);
    step("pre_rst2", 3'b011, 1'b1, 1'b0);
    chk("pre_rst_yq", 32'(yq0), 32'd1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 3'b011, 1'b1, 1'b0);
    chk("post_rst_rise", 32'(r0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
